// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and burst helpers for the multi-manager arbiter.
package ahb_pkg;

  localparam int unsigned BEATS_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  // Total beats of a burst; 0 marks the undefined-length INCR burst.
  function automatic logic [BEATS_W-1:0] burst_beats(hburst_t b);
    logic [BEATS_W-1:0] n;
    case (b)
      SINGLE:        n = 5'd1;
      INCR:          n = 5'd0;
      WRAP4, INCR4:  n = 5'd4;
      WRAP8, INCR8:  n = 5'd8;
      default:       n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_mmgr_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: searches from rr_ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int unsigned MANAGERS = 4,
  parameter int unsigned IDW      = (MANAGERS > 1) ? $clog2(MANAGERS) : 1
) (
  input  logic [MANAGERS-1:0] req_i,
  input  logic [IDW-1:0]      rr_ptr_i,
  output logic [IDW-1:0]      grant_o,
  output logic                grant_valid_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= MANAGERS; k++) begin
      idx = (32'(rr_ptr_i) + k) % MANAGERS;
      if (!found && req_i[IDW'(idx)]) begin
        found   = 1'b1;
        grant_o = IDW'(idx);
      end
    end
    grant_valid_o = |req_i;
  end

endmodule

// File: rtl/ahb_mmgr_arbiter.sv
// Multi-manager AHB-lite stage: round-robin address grant with burst locking
// and routing of the pipelined data-phase return to its owning manager.
module ahb_mmgr_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned MANAGERS   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           i_hclk,
  input  logic                           i_hreset,
  input  logic [MANAGERS*ADDR_WIDTH-1:0] i_m_haddr,
  input  logic [MANAGERS*2-1:0]          i_m_htrans,
  input  logic [MANAGERS*3-1:0]          i_m_hburst,
  input  logic [MANAGERS-1:0]            i_m_hwrite,
  input  logic [MANAGERS*3-1:0]          i_m_hsize,
  input  logic [MANAGERS*DATA_WIDTH-1:0] i_m_hwdata,
  output logic [MANAGERS-1:0]            o_m_hready,
  output logic [MANAGERS-1:0]            o_m_hresp,
  output logic [MANAGERS*DATA_WIDTH-1:0] o_m_hrdata,
  output logic [ADDR_WIDTH-1:0]          o_s_haddr,
  output logic [1:0]                     o_s_htrans,
  output logic [2:0]                     o_s_hburst,
  output logic                           o_s_hwrite,
  output logic [2:0]                     o_s_hsize,
  output logic [DATA_WIDTH-1:0]          o_s_hwdata,
  input  logic                           i_s_hready,
  input  logic                           i_s_hresp,
  input  logic [DATA_WIDTH-1:0]          i_s_hrdata
);

  localparam int unsigned IDW = (MANAGERS > 1) ? $clog2(MANAGERS) : 1;

  htrans_t               m_htrans [MANAGERS];
  hburst_t               m_hburst [MANAGERS];
  logic [ADDR_WIDTH-1:0] m_haddr  [MANAGERS];
  logic [2:0]            m_hsize  [MANAGERS];
  logic [DATA_WIDTH-1:0] m_hwdata [MANAGERS];
  logic [MANAGERS-1:0]   req;
  logic [MANAGERS-1:0]   dp_sel;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [BEATS_W-1:0] beats_left_q, beats_left_d;
  logic               dp_valid_q, dp_valid_d;
  logic [IDW-1:0]     dp_owner_q, dp_owner_d;

  logic [IDW-1:0] arb_grant;
  logic           arb_valid;
  logic           lock_eff;
  logic [IDW-1:0] grant;
  logic           grant_valid;
  htrans_t        g_trans;
  hburst_t        g_burst;
  logic           accept;

  for (genvar g = 0; g < MANAGERS; g++) begin : g_unpack
    assign m_htrans[g] = htrans_t'(i_m_htrans[2*g +: 2]);
    assign m_hburst[g] = hburst_t'(i_m_hburst[3*g +: 3]);
    assign m_haddr[g]  = i_m_haddr[ADDR_WIDTH*g +: ADDR_WIDTH];
    assign m_hsize[g]  = i_m_hsize[3*g +: 3];
    assign m_hwdata[g] = i_m_hwdata[DATA_WIDTH*g +: DATA_WIDTH];
    assign req[g]      = (m_htrans[g] == NONSEQ);
  end

  rr_arbiter #(
    .MANAGERS (MANAGERS),
    .IDW      (IDW)
  ) u_rr_arbiter (
    .req_i         (req),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  // A NONSEQ from the lock owner ends its burst and re-arbitrates immediately.
  assign lock_eff    = lock_q && (m_htrans[owner_q] != NONSEQ);
  assign grant       = lock_eff ? owner_q : arb_grant;
  assign grant_valid = lock_eff || arb_valid;
  assign g_trans     = m_htrans[grant];
  assign g_burst     = m_hburst[grant];
  assign accept      = i_s_hready && grant_valid && ((g_trans == NONSEQ) || (g_trans == SEQ));

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    dp_valid_d   = dp_valid_q;
    dp_owner_d   = dp_owner_q;
    if (i_s_hready) begin
      if (accept) begin
        dp_valid_d = 1'b1;
        dp_owner_d = grant;
        if (g_trans == NONSEQ) begin
          rr_ptr_d     = grant;
          owner_d      = grant;
          lock_d       = (g_burst != SINGLE);
          beats_left_d = '0;
          if ((g_burst != SINGLE) && (g_burst != INCR)) begin
            beats_left_d = burst_beats(g_burst) - 5'd1;
          end
        end else if (lock_q && (g_burst != INCR)) begin
          beats_left_d = beats_left_q - 5'd1;
          if (beats_left_q == 5'd1) begin
            lock_d = 1'b0;
          end
        end
      end else begin
        dp_valid_d = 1'b0;
        // Owner going IDLE ends an INCR burst or cancels any burst after ERROR.
        if (lock_q && (m_htrans[owner_q] == IDLE)) begin
          lock_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      rr_ptr_q     <= IDW'(MANAGERS - 1);
      lock_q       <= 1'b0;
      owner_q      <= '0;
      beats_left_q <= '0;
      dp_valid_q   <= 1'b0;
      dp_owner_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      dp_valid_q   <= dp_valid_d;
      dp_owner_q   <= dp_owner_d;
    end
  end

  assign o_s_htrans = grant_valid ? g_trans          : IDLE;
  assign o_s_haddr  = grant_valid ? m_haddr[grant]   : '0;
  assign o_s_hburst = grant_valid ? g_burst          : SINGLE;
  assign o_s_hwrite = grant_valid ? i_m_hwrite[grant] : 1'b0;
  assign o_s_hsize  = grant_valid ? m_hsize[grant]   : 3'd0;
  assign o_s_hwdata = dp_valid_q  ? m_hwdata[dp_owner_q] : '0;

  for (genvar g = 0; g < MANAGERS; g++) begin : g_resp
    assign dp_sel[g]     = dp_valid_q && (dp_owner_q == IDW'(g));
    assign o_m_hready[g] = (dp_sel[g] || (grant_valid && (grant == IDW'(g)))) ? i_s_hready
                                                                               : !req[g];
    assign o_m_hresp[g]  = dp_sel[g] && i_s_hresp;
    assign o_m_hrdata[DATA_WIDTH*g +: DATA_WIDTH] = dp_sel[g] ? i_s_hrdata : '0;
  end

endmodule

// File: tb/tb_ahb_mmgr_arbiter.sv
// Bench for ahb_mmgr_arbiter: directed scenarios plus randomized managers
// checked against a cycle-level reference model of the arbitration rules.
module tb_ahb_mmgr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    tr [N];
  logic [2:0]    hb [N];
  logic [AW-1:0] ad [N];
  logic          wr [N];
  logic [2:0]    sz [N];
  logic [DW-1:0] wd [N];

  logic [N*AW-1:0] m_haddr_f;
  logic [N*2-1:0]  m_htrans_f;
  logic [N*3-1:0]  m_hburst_f;
  logic [N-1:0]    m_hwrite_f;
  logic [N*3-1:0]  m_hsize_f;
  logic [N*DW-1:0] m_hwdata_f;

  logic          s_hready, s_hresp;
  logic [DW-1:0] s_hrdata;

  logic [N-1:0]    o_m_hready, o_m_hresp;
  logic [N*DW-1:0] o_m_hrdata;
  logic [AW-1:0]   o_s_haddr;
  logic [1:0]      o_s_htrans;
  logic [2:0]      o_s_hburst, o_s_hsize;
  logic            o_s_hwrite;
  logic [DW-1:0]   o_s_hwdata;

  int checks = 0;
  int errors = 0;

  always_comb begin
    m_haddr_f = '0; m_htrans_f = '0; m_hburst_f = '0;
    m_hwrite_f = '0; m_hsize_f = '0; m_hwdata_f = '0;
    for (int i = 0; i < N; i++) begin
      m_haddr_f[AW*i +: AW]  = ad[i];
      m_htrans_f[2*i +: 2]   = tr[i];
      m_hburst_f[3*i +: 3]   = hb[i];
      m_hwrite_f[i]          = wr[i];
      m_hsize_f[3*i +: 3]    = sz[i];
      m_hwdata_f[DW*i +: DW] = wd[i];
    end
  end

  ahb_mmgr_arbiter #(.MANAGERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_hclk     (clk),
    .i_hreset   (rst),
    .i_m_haddr  (m_haddr_f),
    .i_m_htrans (m_htrans_f),
    .i_m_hburst (m_hburst_f),
    .i_m_hwrite (m_hwrite_f),
    .i_m_hsize  (m_hsize_f),
    .i_m_hwdata (m_hwdata_f),
    .o_m_hready (o_m_hready),
    .o_m_hresp  (o_m_hresp),
    .o_m_hrdata (o_m_hrdata),
    .o_s_haddr  (o_s_haddr),
    .o_s_htrans (o_s_htrans),
    .o_s_hburst (o_s_hburst),
    .o_s_hwrite (o_s_hwrite),
    .o_s_hsize  (o_s_hsize),
    .o_s_hwdata (o_s_hwdata),
    .i_s_hready (s_hready),
    .i_s_hresp  (s_hresp),
    .i_s_hrdata (s_hrdata)
  );

  // ---------------- reference model ----------------
  int  mp = N - 1, mo = 0, mleft = 0, mdpo = 0;
  bit  mlock = 0, mdpv = 0;
  int  eg;
  bit  egv, eacc;
  logic [1:0]      e_htrans;
  logic [AW-1:0]   e_haddr;
  logic [2:0]      e_hburst, e_hsize;
  logic            e_hwrite;
  logic [DW-1:0]   e_hwdata;
  logic [N-1:0]    e_hready, e_hresp;
  logic [N*DW-1:0] e_hrdata;

  function automatic int tb_beats(int b);
    if (b == 0) return 1;
    if (b == 1) return 0;
    return 4 << ((b - 2) / 2);
  endfunction

  task automatic model_eval();
    bit keep_lock;
    keep_lock = mlock && (tr[mo] != 2'd2);
    egv = 0;
    eg  = 0;
    if (keep_lock) begin
      egv = 1;
      eg  = mo;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mp + k) % N;
        if (!egv && tr[c] == 2'd2) begin
          egv = 1;
          eg  = c;
        end
      end
    end
    eacc     = s_hready && egv && (tr[eg] == 2'd2 || tr[eg] == 2'd3);
    e_htrans = egv ? tr[eg] : 2'd0;
    e_haddr  = egv ? ad[eg] : '0;
    e_hburst = egv ? hb[eg] : 3'd0;
    e_hwrite = egv ? wr[eg] : 1'b0;
    e_hsize  = egv ? sz[eg] : 3'd0;
    e_hwdata = mdpv ? wd[mdpo] : '0;
    e_hrdata = '0;
    for (int i = 0; i < N; i++) begin
      bit sel;
      sel = mdpv && (mdpo == i);
      e_hready[i] = (sel || (egv && eg == i)) ? s_hready : (tr[i] != 2'd2);
      e_hresp[i]  = sel && s_hresp;
      if (sel) e_hrdata[DW*i +: DW] = s_hrdata;
    end
  endtask

  task automatic model_update();
    model_eval();
    if (rst) begin
      mp = N - 1; mlock = 0; mo = 0; mleft = 0; mdpv = 0; mdpo = 0;
    end else if (s_hready) begin
      if (eacc) begin
        mdpv = 1;
        mdpo = eg;
        if (tr[eg] == 2'd2) begin
          mp = eg;
          mo = eg;
          if (hb[eg] == 3'd0) mlock = 0;
          else if (hb[eg] == 3'd1) begin mlock = 1; mleft = -1; end
          else begin mlock = 1; mleft = tb_beats(int'(hb[eg])) - 1; end
        end else if (mlock && mleft > 0) begin
          mleft--;
          if (mleft == 0) mlock = 0;
        end
      end else begin
        mdpv = 0;
        if (mlock && tr[mo] == 2'd0) mlock = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) tr[i] = 2'd0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    step();
    step();
    @(negedge clk);
    checks++; if (o_s_htrans !== 2'd0) begin errors++; $display("FAIL reset_htrans: got %0d exp 0", o_s_htrans); end
    checks++; if (o_s_haddr !== '0) begin errors++; $display("FAIL reset_haddr: got %h exp 0", o_s_haddr); end
    checks++; if (o_s_hwdata !== '0) begin errors++; $display("FAIL reset_hwdata: got %h exp 0", o_s_hwdata); end
    checks++; if (o_m_hready !== 4'b1111) begin errors++; $display("FAIL reset_hready: got %b exp 1111", o_m_hready); end
    checks++; if (o_m_hresp !== 4'b0000 || o_m_hrdata !== '0) begin errors++; $display("FAIL reset_resp: got %b/%h exp 0/0", o_m_hresp, o_m_hrdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    tr[0] = 2'd2; hb[0] = 3'd0; ad[0] = 32'h1000; wr[0] = 1'b1; sz[0] = 3'd2;
    tr[2] = 2'd2; hb[2] = 3'd0; ad[2] = 32'h2000; wr[2] = 1'b1; sz[2] = 3'd2;
    @(negedge clk);
    checks++; if (o_m_hready !== 4'b1011) begin errors++; $display("FAIL rr_first_hready: got %b exp 1011", o_m_hready); end
    checks++; if (o_s_haddr !== 32'h1000) begin errors++; $display("FAIL rr_first_addr: got %h exp 00001000", o_s_haddr); end
    step();
    tr[0] = 2'd0;
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h2000 || o_s_htrans !== 2'd2) begin errors++; $display("FAIL rr_second_addr: got %h/%0d exp 00002000/2", o_s_haddr, o_s_htrans); end
    checks++; if (o_m_hready !== 4'b1111) begin errors++; $display("FAIL rr_second_hready: got %b exp 1111", o_m_hready); end
    step();
    tr[2] = 2'd0;
    step();
  endtask

  task automatic test_incr4_burst();
    logic [AW-1:0] exp_a;
    tr[1] = 2'd2; hb[1] = 3'd3; ad[1] = 32'h10; wr[1] = 1'b1; sz[1] = 3'd2;
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h10 || o_s_htrans !== 2'd2) begin errors++; $display("FAIL incr4_beat0: got %h/%0d exp 00000010/2", o_s_haddr, o_s_htrans); end
    step();
    tr[3] = 2'd2; hb[3] = 3'd0; ad[3] = 32'h300; wr[3] = 1'b0; sz[3] = 3'd2;
    for (int b = 1; b < 4; b++) begin
      tr[1] = 2'd3;
      ad[1] = 32'h10 + 32'(4 * b);
      exp_a = ad[1];
      @(negedge clk);
      checks++; if (o_s_haddr !== exp_a || o_s_htrans !== 2'd3) begin errors++; $display("FAIL incr4_beat%0d: got %h/%0d exp %h/3", b, o_s_haddr, o_s_htrans, exp_a); end
      checks++; if (o_m_hready[3] !== 1'b0) begin errors++; $display("FAIL incr4_stall%0d: got %b exp 0", b, o_m_hready[3]); end
      step();
    end
    tr[1] = 2'd0;
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h300 || o_m_hready[3] !== 1'b1) begin errors++; $display("FAIL incr4_handover: got %h/%b exp 00000300/1", o_s_haddr, o_m_hready[3]); end
    step();
    tr[3] = 2'd0;
    step();
  endtask

  task automatic test_wait_states();
    logic [DW-1:0] rd;
    logic [N*DW-1:0] exp_rd;
    tr[0] = 2'd2; hb[0] = 3'd0; ad[0] = 32'h40; wr[0] = 1'b0;
    step();
    tr[0] = 2'd0;
    s_hready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      checks++; if (o_m_hready[0] !== 1'b0) begin errors++; $display("FAIL wait_hready%0d: got %b exp 0", w, o_m_hready[0]); end
      step();
    end
    s_hready = 1'b1;
    rd = $urandom;
    s_hrdata = rd;
    exp_rd = '0;
    exp_rd[DW-1:0] = rd;
    @(negedge clk);
    checks++; if (o_m_hready[0] !== 1'b1) begin errors++; $display("FAIL wait_ready: got %b exp 1", o_m_hready[0]); end
    checks++; if (o_m_hrdata !== exp_rd) begin errors++; $display("FAIL wait_rdata: got %h exp %h", o_m_hrdata, exp_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] wv;
    wv = $urandom;
    tr[2] = 2'd2; hb[2] = 3'd0; ad[2] = 32'h200; wr[2] = 1'b1; wd[2] = wv;
    step();
    tr[2] = 2'd0;
    tr[3] = 2'd2; hb[3] = 3'd0; ad[3] = 32'h300; wr[3] = 1'b0; wd[3] = ~wv;
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h300 || o_s_hwrite !== 1'b0) begin errors++; $display("FAIL b2b_addr: got %h/%b exp 00000300/0", o_s_haddr, o_s_hwrite); end
    checks++; if (o_s_hwdata !== wv) begin errors++; $display("FAIL b2b_wdata: got %h exp %h", o_s_hwdata, wv); end
    step();
    tr[3] = 2'd0;
    step();
  endtask

  task automatic test_incr_undefined();
    logic [AW-1:0] exp_a;
    tr[1] = 2'd2; hb[1] = 3'd1; ad[1] = 32'h100; wr[1] = 1'b1;
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h100) begin errors++; $display("FAIL incr_beat0: got %h exp 00000100", o_s_haddr); end
    step();
    tr[0] = 2'd2; hb[0] = 3'd0; ad[0] = 32'h500; wr[0] = 1'b0;
    for (int b = 1; b < 5; b++) begin
      tr[1] = 2'd3;
      ad[1] = 32'h100 + 32'(4 * b);
      exp_a = ad[1];
      @(negedge clk);
      checks++; if (o_s_haddr !== exp_a || o_m_hready[0] !== 1'b0) begin errors++; $display("FAIL incr_beat%0d: got %h/%b exp %h/0", b, o_s_haddr, o_m_hready[0], exp_a); end
      step();
    end
    tr[1] = 2'd0;
    @(negedge clk);
    checks++; if (o_s_htrans !== 2'd0 || o_m_hready[0] !== 1'b0) begin errors++; $display("FAIL incr_idle: got %0d/%b exp 0/0", o_s_htrans, o_m_hready[0]); end
    step();
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h500 || o_s_htrans !== 2'd2 || o_m_hready[0] !== 1'b1) begin errors++; $display("FAIL incr_release: got %h/%0d/%b exp 00000500/2/1", o_s_haddr, o_s_htrans, o_m_hready[0]); end
    step();
    tr[0] = 2'd0;
    step();
  endtask

  task automatic test_reset_midburst();
    tr[1] = 2'd2; hb[1] = 3'd4; ad[1] = 32'h20; wr[1] = 1'b1;
    step();
    tr[1] = 2'd3; ad[1] = 32'h24;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ad[1] = 32'h28;
    @(negedge clk);
    checks++; if (o_s_htrans !== 2'd0) begin errors++; $display("FAIL rst_mid_htrans: got %0d exp 0", o_s_htrans); end
    checks++; if (o_m_hready !== 4'b1111) begin errors++; $display("FAIL rst_mid_hready: got %b exp 1111", o_m_hready); end
    step();
    tr[1] = 2'd0;
    tr[0] = 2'd2; hb[0] = 3'd0; ad[0] = 32'h600;
    tr[3] = 2'd2; hb[3] = 3'd0; ad[3] = 32'h700;
    @(negedge clk);
    checks++; if (o_s_haddr !== 32'h600) begin errors++; $display("FAIL rst_mid_first: got %h exp 00000600", o_s_haddr); end
    step();
    idle_all();
    step();
    step();
  endtask

  // ---------------- randomized managers ----------------
  int rem [N];

  task automatic agent_next();
    for (int i = 0; i < N; i++) begin
      bit acc;
      acc = eacc && (eg == i);
      if (acc) begin
        if (tr[i] == 2'd2)
          rem[i] = (hb[i] == 3'd1) ? int'($urandom_range(1, 4)) : tb_beats(int'(hb[i])) - 1;
        else if (tr[i] == 2'd3)
          rem[i]--;
        ad[i] = ad[i] + 32'd4;
      end
      wd[i] = $urandom;
      if (!acc && (tr[i] == 2'd2 || tr[i] == 2'd3)) continue;
      if (rem[i] > 0) begin
        tr[i] = ($urandom_range(0, 4) == 0) ? 2'd1 : 2'd3;
      end else if ($urandom_range(0, 2) == 0) begin
        tr[i] = 2'd2;
        hb[i] = 3'($urandom_range(0, 7));
        ad[i] = $urandom & 32'hFFFF_FFFC;
        wr[i] = 1'($urandom_range(0, 1));
        sz[i] = 3'($urandom_range(0, 2));
      end else begin
        tr[i] = 2'd0;
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    idle_all();
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = ($urandom_range(0, 7) == 0);
      s_hrdata = $urandom;
      model_eval();
      @(negedge clk);
      checks++; if (o_s_htrans !== e_htrans || o_s_haddr !== e_haddr) begin errors++; $display("FAIL rand_addr c%0d: got %0d/%h exp %0d/%h", cyc, o_s_htrans, o_s_haddr, e_htrans, e_haddr); end
      checks++; if (o_s_hburst !== e_hburst || o_s_hwrite !== e_hwrite || o_s_hsize !== e_hsize) begin errors++; $display("FAIL rand_ctrl c%0d: got %0d/%b/%0d exp %0d/%b/%0d", cyc, o_s_hburst, o_s_hwrite, o_s_hsize, e_hburst, e_hwrite, e_hsize); end
      checks++; if (o_m_hready !== e_hready) begin errors++; $display("FAIL rand_hready c%0d: got %b exp %b", cyc, o_m_hready, e_hready); end
      checks++; if (o_s_hwdata !== e_hwdata) begin errors++; $display("FAIL rand_wdata c%0d: got %h exp %h", cyc, o_s_hwdata, e_hwdata); end
      checks++; if (o_m_hresp !== e_hresp || o_m_hrdata !== e_hrdata) begin errors++; $display("FAIL rand_rdata c%0d: got %b/%h exp %b/%h", cyc, o_m_hresp, o_m_hrdata, e_hresp, e_hrdata); end
      step();
      agent_next();
    end
  endtask

  initial begin
    rst = 1'b1;
    s_hready = 1'b1;
    s_hresp = 1'b0;
    s_hrdata = '0;
    for (int i = 0; i < N; i++) begin
      tr[i] = 2'd0; hb[i] = 3'd0; ad[i] = '0; wr[i] = 1'b0; sz[i] = 3'd0; wd[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_incr4_burst();
    test_wait_states();
    test_back_to_back();
    test_incr_undefined();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
